// File: rtl/id_immd_stage_if.sv
// Bundles the fetch-side and ID-side handshakes of the immediate-decode stage.
// The stage connects through the slave modport; fetch/ID (or a bench) uses master.
interface id_immd_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_instr;
    logic [WIDTH-1:0] in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;
    logic [1:0]       ImmdLocation;
    logic             Signed;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, ImmdLocation, Signed
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, ImmdLocation, Signed
    );
endinterface

// File: rtl/id_immd_stage.sv
// ID-side stage: decodes the immediate format of each fetched instruction and
// buffers it in a 2-entry elastic buffer (OUT plus SKID) feeding the extender.
module id_immd_stage #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    id_immd_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_inReady;

    logic [WIDTH-1:0] r_outInstr;
    logic [WIDTH-1:0] r_outPc;
    logic [1:0]       r_outLoc;
    logic             r_outSigned;

    logic [WIDTH-1:0] r_skidInstr;
    logic [WIDTH-1:0] r_skidPc;
    logic [1:0]       r_skidLoc;
    logic             r_skidSigned;

    logic [1:0]       w_decLoc;
    logic             w_decSigned;
    logic             w_accept;
    logic             w_loadOutFromIn;
    logic             w_loadOutFromSkid;
    logic             w_loadSkid;

    assign w_accept = bus.in_valid & r_inReady;

    // Immediate format decode of the incoming opcode; stored with the entry.
    always_comb begin
        w_decLoc    = 2'b11;
        w_decSigned = 1'b0;
        case (bus.in_instr[WIDTH-1 -: 5])
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
                w_decLoc    = 2'b00;
                w_decSigned = 1'b1;
            end
            5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                w_decLoc    = 2'b00;
                w_decSigned = 1'b0;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111: begin
                w_decLoc    = 2'b01;
                w_decSigned = 1'b1;
            end
            5'b10010: begin
                w_decLoc    = 2'b01;
                w_decSigned = 1'b0;
            end
            5'b00100, 5'b00110: begin
                w_decLoc    = 2'b10;
                w_decSigned = 1'b1;
            end
            default: begin
                w_decLoc    = 2'b11;
                w_decSigned = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Flush overrides every transfer; w_accept already folds in r_inReady.
    always_comb begin
        w_nextState       = r_state;
        w_loadOutFromIn   = 1'b0;
        w_loadOutFromSkid = 1'b0;
        w_loadSkid        = 1'b0;
        if (flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_loadOutFromIn = 1'b1;
                        w_nextState     = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && bus.out_ready) begin
                        w_loadOutFromIn = 1'b1;
                    end else if (w_accept) begin
                        w_loadSkid  = 1'b1;
                        w_nextState = TWO;
                    end else if (bus.out_ready) begin
                        w_nextState = EMPTY;
                    end
                end
                TWO: begin
                    if (bus.out_ready) begin
                        w_loadOutFromSkid = 1'b1;
                        w_nextState       = ONE;
                    end
                end
                default: begin
                    w_nextState = EMPTY;
                end
            endcase
        end
    end

    // Registered ready keeps out_ready off the combinational path to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inReady <= 1'b0;
        end else begin
            r_inReady <= (w_nextState != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outInstr  <= '0;
            r_outPc     <= '0;
            r_outLoc    <= 2'b11;
            r_outSigned <= 1'b0;
        end else if (w_loadOutFromIn) begin
            r_outInstr  <= bus.in_instr;
            r_outPc     <= bus.in_pc;
            r_outLoc    <= w_decLoc;
            r_outSigned <= w_decSigned;
        end else if (w_loadOutFromSkid) begin
            r_outInstr  <= r_skidInstr;
            r_outPc     <= r_skidPc;
            r_outLoc    <= r_skidLoc;
            r_outSigned <= r_skidSigned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skidInstr  <= '0;
            r_skidPc     <= '0;
            r_skidLoc    <= 2'b11;
            r_skidSigned <= 1'b0;
        end else if (w_loadSkid) begin
            r_skidInstr  <= bus.in_instr;
            r_skidPc     <= bus.in_pc;
            r_skidLoc    <= w_decLoc;
            r_skidSigned <= w_decSigned;
        end
    end

    assign bus.in_ready     = r_inReady;
    assign bus.out_valid    = (r_state != EMPTY);
    assign bus.out_instr    = r_outInstr;
    assign bus.out_pc       = r_outPc;
    assign bus.ImmdLocation = r_outLoc;
    assign bus.Signed       = r_outSigned;

endmodule

// File: tb/tb_id_immd_stage.sv
// Scenario and randomized checks of id_immd_stage against a queue-based
// FIFO model and a table-driven immediate-format decoder.
module tb_id_immd_stage;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } item_t;

    logic clk;
    logic rst;
    logic flush;

    id_immd_stage_if #(.WIDTH(16)) bus ();

    id_immd_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int    checks;
    int    failures;
    item_t q[$];
    item_t held;
    logic  mReady;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {location, signed} from the opcode table.
    function automatic logic [2:0] refDecode(input logic [15:0] instr);
        int op;
        op = int'(instr[15:11]);
        if (op inside {8, 9, 16, 17, 19})            return 3'b001;
        if (op inside {10, 11, [20:23]})             return 3'b000;
        if (op inside {[12:15], 24, 5, 7})           return 3'b011;
        if (op == 18)                                return 3'b010;
        if (op inside {4, 6})                        return 3'b101;
        return 3'b110;
    endfunction

    // One clock: model follows the inputs present at the edge, then settle to negedge.
    task automatic cycle();
        bit    doPop;
        bit    doPush;
        item_t inItem;
        doPop        = !rst && !flush && (q.size() > 0) && bus.out_ready;
        doPush       = !rst && !flush && bus.in_valid && mReady;
        inItem.instr = bus.in_instr;
        inItem.pc    = bus.in_pc;
        @(posedge clk);
        if (rst) begin
            q.delete();
            held.instr = 16'h0000;
            held.pc    = 16'h0000;
            mReady     = 1'b0;
        end else if (flush) begin
            q.delete();
            mReady = 1'b1;
        end else begin
            if (doPop) void'(q.pop_front());
            if (doPush) q.push_back(inItem);
            mReady = (q.size() < 2);
        end
        if (q.size() > 0) held = q[0];
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h4105;
        bus.in_pc     = 16'h0010;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.ImmdLocation !== 2'b11 || bus.Signed !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_decode got=%b/%b want=11/0", bus.ImmdLocation, bus.Signed);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b want=0", bus.in_ready);
        end
        checks++;
        if (bus.out_instr !== 16'h0000 || bus.out_pc !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h/%h want=0000/0000", bus.out_instr, bus.out_pc);
        end
        idle();
        cycle();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_pass_through();
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h4105;
        bus.in_pc     = 16'h0002;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h4105 || bus.out_pc !== 16'h0002) begin
            failures++;
            $display("[TB] FAIL pass_data got v=%b %h/%h want 1 4105/0002", bus.out_valid, bus.out_instr, bus.out_pc);
        end
        checks++;
        if (bus.ImmdLocation !== 2'b00 || bus.Signed !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pass_decode got=%b/%b want=00/1", bus.ImmdLocation, bus.Signed);
        end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 16'h4105) begin
            failures++;
            $display("[TB] FAIL pass_drain got v=%b %h want 0 4105(held)", bus.out_valid, bus.out_instr);
        end
    endtask

    task automatic test_decode_sweep();
        logic [4:0] ops  [4] = '{5'b10010, 5'b00100, 5'b01010, 5'b00000};
        logic [1:0] eLoc [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
        logic       eSgn [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] sent[4];
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sent[i]      = {ops[i], 11'($urandom)};
            bus.in_valid = 1'b1;
            bus.in_instr = sent[i];
            bus.in_pc    = 16'h0100 + 16'(2 * i);
            cycle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== sent[i] ||
                bus.ImmdLocation !== eLoc[i] || bus.Signed !== eSgn[i]) begin
                failures++;
                $display("[TB] FAIL sweep_%0d got v=%b %h %b/%b want 1 %h %b/%b", i,
                         bus.out_valid, bus.out_instr, bus.ImmdLocation, bus.Signed,
                         sent[i], eLoc[i], eSgn[i]);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [15:0] words[3] = '{16'h6a11, 16'h9c22, 16'h2b33};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = words[i];
            bus.in_pc    = 16'h0200 + 16'(2 * i);
            cycle();
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== words[0] || bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_full got v=%b %h rdy=%b want 1 %h 0", bus.out_valid, bus.out_instr, bus.in_ready, words[0]);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== words[i] || bus.out_pc !== 16'h0200 + 16'(2 * i)) begin
                failures++;
                $display("[TB] FAIL bp_order_%0d got v=%b %h/%h want 1 %h", i, bus.out_valid, bus.out_instr, bus.out_pc, words[i]);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_drain got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic fillTwo(input logic [15:0] a, input logic [15:0] b);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = a;
        bus.in_pc     = 16'h0300;
        cycle();
        bus.in_instr  = b;
        bus.in_pc     = 16'h0302;
        cycle();
    endtask

    task automatic test_flush_full();
        fillTwo(16'h4111, 16'h4222);
        bus.in_instr = 16'h4333;
        flush        = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_state got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        bus.in_instr  = 16'h8d44;
        bus.in_pc     = 16'h0400;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h8d44 || bus.ImmdLocation !== 2'b00 || bus.Signed !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_next got v=%b %h %b/%b want 1 8d44 00/1", bus.out_valid, bus.out_instr, bus.ImmdLocation, bus.Signed);
        end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_stale got v=%b %h want 0", bus.out_valid, bus.out_instr);
        end
    endtask

    task automatic test_reset_mid();
        fillTwo(16'h6155, 16'h6266);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_instr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL rstmid_state got v=%b rdy=%b %h want 0 0 0000", bus.out_valid, bus.in_ready, bus.out_instr);
        end
        cycle();
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h3a77;
        bus.in_pc    = 16'h0500;
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h3a77 || bus.ImmdLocation !== 2'b01 || bus.Signed !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_new got v=%b %h %b/%b want 1 3a77 01/1", bus.out_valid, bus.out_instr, bus.ImmdLocation, bus.Signed);
        end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_alone got v=%b %h want 0", bus.out_valid, bus.out_instr);
        end
    endtask

    task automatic test_random();
        logic [2:0] dec;
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            bus.in_instr  = 16'($urandom);
            bus.in_pc     = 16'($urandom);
            flush         = ($urandom_range(0, 99) < 5);
            rst           = ($urandom_range(0, 99) < 2);
            cycle();
            dec = refDecode(held.instr);
            checks++;
            if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== mReady) begin
                failures++;
                $display("[TB] FAIL rand_ctrl_%0d got v=%b rdy=%b want v=%b rdy=%b", n,
                         bus.out_valid, bus.in_ready, (q.size() > 0), mReady);
            end
            checks++;
            if (bus.out_instr !== held.instr || bus.out_pc !== held.pc ||
                bus.ImmdLocation !== dec[2:1] || bus.Signed !== dec[0]) begin
                failures++;
                $display("[TB] FAIL rand_data_%0d got %h/%h %b/%b want %h/%h %b/%b", n,
                         bus.out_instr, bus.out_pc, bus.ImmdLocation, bus.Signed,
                         held.instr, held.pc, dec[2:1], dec[0]);
            end
        end
        idle();
        cycle();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        mReady        = 1'b0;
        held.instr    = 16'h0000;
        held.pc       = 16'h0000;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 16'h0000;
        bus.in_pc     = 16'h0000;
        bus.out_ready = 1'b0;
        test_reset();
        test_pass_through();
        test_decode_sweep();
        test_backpressure();
        test_flush_full();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
